// File: rtl/uart_frame_parser_if.sv
// Byte-level link shared by the UART receiver side, the frame parser and the payload consumer.
// The parser connects through the slave modport; the byte source/consumer through master.
interface uart_frame_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;
   logic       frame_ok;
   logic       err_pulse;
   logic [1:0] err_code;
   logic       overrun;

   modport master (
      output rx_data, rx_valid, rx_error, m_ready,
      input  m_data, m_valid, m_last, frame_ok, err_pulse, err_code, overrun
   );

   modport slave (
      input  rx_data, rx_valid, rx_error, m_ready,
      output m_data, m_valid, m_last, frame_ok, err_pulse, err_code, overrun
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Sync-hunting, length-prefixed frame parser with additive checksum.
// Good payloads are buffered, then replayed on a valid/ready stream with a last flag.
module uart_frame_parser #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input logic                clk,
   input logic                rst,
   uart_frame_parser_if.slave io_bus
);
   localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam bit              TMO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [TW-1:0]   TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   localparam logic [1:0] ERR_FRAMING  = 2'd0;
   localparam logic [1:0] ERR_LENGTH   = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_EMIT    = 3'd4
   } state_t;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_len, w_len_nxt;
   logic [7:0]    r_idx, w_idx_nxt;
   logic [7:0]    r_csum, w_csum_nxt;
   logic [TW-1:0] r_tmo, w_tmo_nxt;
   logic [7:0]    r_buf [MAX_LEN];

   logic [7:0]    r_m_data, w_m_data_nxt;
   logic          r_m_valid, w_m_valid_nxt;
   logic          r_m_last, w_m_last_nxt;
   logic          r_frame_ok, w_frame_ok_nxt;
   logic          r_err_pulse, w_err_pulse_nxt;
   logic [1:0]    r_err_code, w_err_code_nxt;
   logic          r_overrun, w_overrun_nxt;

   logic          w_buf_we;
   logic          w_abort;
   logic [1:0]    w_abort_code;
   logic          w_in_frame;
   logic [7:0]    w_idx_inc;
   logic [7:0]    w_last_idx;

   assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
   assign w_idx_inc  = r_idx + 8'd1;
   assign w_last_idx = r_len - 8'd1;

   // Next state, datapath and next registered outputs for the current byte or stream handshake.
   always_comb begin
      w_state_nxt     = r_state;
      w_len_nxt       = r_len;
      w_idx_nxt       = r_idx;
      w_csum_nxt      = r_csum;
      w_tmo_nxt       = '0;
      w_m_data_nxt    = r_m_data;
      w_m_valid_nxt   = r_m_valid;
      w_m_last_nxt    = r_m_last;
      w_frame_ok_nxt  = 1'b0;
      w_err_pulse_nxt = 1'b0;
      w_err_code_nxt  = r_err_code;
      w_overrun_nxt   = 1'b0;
      w_buf_we        = 1'b0;
      w_abort         = 1'b0;
      w_abort_code    = ERR_FRAMING;

      case (r_state)
         ST_HUNT: begin
            if (io_bus.rx_valid && io_bus.rx_error) begin
               w_abort = 1'b1;
            end else if (io_bus.rx_valid && (io_bus.rx_data == SYNC_BYTE)) begin
               w_state_nxt = ST_LEN;
            end else begin
               w_state_nxt = ST_HUNT;
            end
         end
         ST_LEN: begin
            if (io_bus.rx_valid && io_bus.rx_error) begin
               w_abort = 1'b1;
            end else if (io_bus.rx_valid) begin
               if ((io_bus.rx_data != 8'd0) && (io_bus.rx_data <= MAX_LEN_B)) begin
                  w_len_nxt   = io_bus.rx_data;
                  w_csum_nxt  = io_bus.rx_data;
                  w_idx_nxt   = 8'd0;
                  w_state_nxt = ST_PAYLOAD;
               end else begin
                  w_abort      = 1'b1;
                  w_abort_code = ERR_LENGTH;
               end
            end else begin
               w_state_nxt = ST_LEN;
            end
         end
         ST_PAYLOAD: begin
            if (io_bus.rx_valid && io_bus.rx_error) begin
               w_abort = 1'b1;
            end else if (io_bus.rx_valid) begin
               w_buf_we   = 1'b1;
               w_csum_nxt = csum_add(r_csum, io_bus.rx_data);
               w_idx_nxt  = w_idx_inc;
               if (r_idx == w_last_idx) begin
                  w_state_nxt = ST_CSUM;
               end else begin
                  w_state_nxt = ST_PAYLOAD;
               end
            end else begin
               w_state_nxt = ST_PAYLOAD;
            end
         end
         ST_CSUM: begin
            if (io_bus.rx_valid && io_bus.rx_error) begin
               w_abort = 1'b1;
            end else if (io_bus.rx_valid) begin
               if (io_bus.rx_data == r_csum) begin
                  // Present the first byte straight away so it can transfer on the frame_ok cycle.
                  w_state_nxt    = ST_EMIT;
                  w_idx_nxt      = 8'd0;
                  w_frame_ok_nxt = 1'b1;
                  w_m_valid_nxt  = 1'b1;
                  w_m_data_nxt   = r_buf[0];
                  w_m_last_nxt   = (r_len == 8'd1);
               end else begin
                  w_abort      = 1'b1;
                  w_abort_code = ERR_CHECKSUM;
               end
            end else begin
               w_state_nxt = ST_CSUM;
            end
         end
         ST_EMIT: begin
            w_overrun_nxt = io_bus.rx_valid;
            if (r_m_valid && io_bus.m_ready && r_m_last) begin
               w_m_valid_nxt = 1'b0;
               w_m_last_nxt  = 1'b0;
               w_idx_nxt     = 8'd0;
               w_state_nxt   = ST_HUNT;
            end else if (r_m_valid && io_bus.m_ready) begin
               w_idx_nxt    = w_idx_inc;
               w_m_data_nxt = r_buf[w_idx_inc[IW-1:0]];
               w_m_last_nxt = (w_idx_inc == w_last_idx);
            end else begin
               w_state_nxt = ST_EMIT;
            end
         end
         default: begin
            w_state_nxt = ST_HUNT;
         end
      endcase

      // Inter-byte timer: any received byte restarts it, so a byte on the expiry cycle wins.
      if (w_in_frame && !io_bus.rx_valid) begin
         if (TMO_EN && (r_tmo == TMO_LAST)) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_TIMEOUT;
         end else begin
            w_tmo_nxt = r_tmo + TW'(1);
         end
      end else begin
         w_tmo_nxt = '0;
      end

      if (w_abort) begin
         w_state_nxt     = ST_HUNT;
         w_err_pulse_nxt = 1'b1;
         w_err_code_nxt  = w_abort_code;
         w_idx_nxt       = 8'd0;
         w_tmo_nxt       = '0;
      end else begin
         w_err_pulse_nxt = 1'b0;
      end
   end

   // Parser state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_HUNT;
         r_len       <= 8'd0;
         r_idx       <= 8'd0;
         r_csum      <= 8'd0;
         r_tmo       <= '0;
         r_m_data    <= 8'd0;
         r_m_valid   <= 1'b0;
         r_m_last    <= 1'b0;
         r_frame_ok  <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_code  <= 2'd0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_idx       <= w_idx_nxt;
         r_csum      <= w_csum_nxt;
         r_tmo       <= w_tmo_nxt;
         r_m_data    <= w_m_data_nxt;
         r_m_valid   <= w_m_valid_nxt;
         r_m_last    <= w_m_last_nxt;
         r_frame_ok  <= w_frame_ok_nxt;
         r_err_pulse <= w_err_pulse_nxt;
         r_err_code  <= w_err_code_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   // Payload storage; entries are always written in the current frame before they are read.
   always_ff @(posedge clk) begin
      if (w_buf_we) begin
         r_buf[r_idx[IW-1:0]] <= io_bus.rx_data;
      end
   end

   assign io_bus.m_data    = r_m_data;
   assign io_bus.m_valid   = r_m_valid;
   assign io_bus.m_last    = r_m_last;
   assign io_bus.frame_ok  = r_frame_ok;
   assign io_bus.err_pulse = r_err_pulse;
   assign io_bus.err_code  = r_err_code;
   assign io_bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame vector table, hand-written corner sequences and
// random frames whose expected outcome is derived from the framing rules.
module tb_uart_frame_parser;
   localparam int MAXL = 16;
   localparam int TMO  = 20;

   logic clk = 1'b0;
   logic rst;
   uart_frame_parser_if bus();

   uart_frame_parser #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN(MAXL),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io_bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b [0:7];
      int         nb;
      int         err_pos;
      int         exp_frames;
      int         exp_err;
      int         exp_n;
      logic [7:0] exp_d [0:3];
   } vec_t;

   vec_t vt [8];

   int n_checks = 0;
   int n_fail = 0;
   int ready_mode = 0;
   int obs_ok = 0;
   int obs_ov = 0;
   int exp_ok = 0;
   int exp_ov = 0;
   logic [1:0] obs_err [$];
   logic [1:0] exp_err [$];
   logic [8:0] obs_d [$];
   logic [8:0] exp_d [$];
   logic prev_stall = 1'b0;
   logic [7:0] prev_d = 8'd0;
   logic prev_l = 1'b0;

   function automatic void chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(logic [7:0] d, logic e);
      bus.rx_data  = d;
      bus.rx_error = e;
      bus.rx_valid = 1'b1;
      tick(1);
      bus.rx_valid = 1'b0;
      bus.rx_error = 1'b0;
   endtask

   task automatic clear_obs();
      obs_ok = 0; obs_ov = 0; exp_ok = 0; exp_ov = 0;
      obs_err.delete(); exp_err.delete(); obs_d.delete(); exp_d.delete();
   endtask

   task automatic wait_emit_done(string nm);
      int k = 0;
      while (bus.m_valid === 1'b1 && k < 400) begin
         tick(1);
         k++;
      end
      chk({nm, "_emit_bound"}, int'(bus.m_valid === 1'b1), 0);
      tick(2);
   endtask

   task automatic compare(string nm);
      chk({nm, "_frame_ok"}, obs_ok, exp_ok);
      chk({nm, "_overrun"}, obs_ov, exp_ov);
      chk({nm, "_n_err"}, obs_err.size(), exp_err.size());
      for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
         chk({nm, "_err_code"}, int'(obs_err[i]), int'(exp_err[i]));
      chk({nm, "_n_bytes"}, obs_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++)
         chk({nm, "_last_byte"}, int'(obs_d[i]), int'(exp_d[i]));
      clear_obs();
   endtask

   task automatic check_zero(string nm);
      chk({nm, "_m_valid"}, int'(bus.m_valid), 0);
      chk({nm, "_m_last"}, int'(bus.m_last), 0);
      chk({nm, "_m_data"}, int'(bus.m_data), 0);
      chk({nm, "_frame_ok"}, int'(bus.frame_ok), 0);
      chk({nm, "_err_pulse"}, int'(bus.err_pulse), 0);
      chk({nm, "_err_code"}, int'(bus.err_code), 0);
      chk({nm, "_overrun"}, int'(bus.overrun), 0);
   endtask

   // m_ready pattern: 0 always ready, 1 toggle, 2 random, other held low.
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            2:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: records stream transfers and pulses, checks hold-while-stalled.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", int'(bus.m_valid), 1);
               chk("hold_data", int'(bus.m_data), int'(prev_d));
               chk("hold_last", int'(bus.m_last), int'(prev_l));
            end
            if (bus.m_valid && bus.m_ready) obs_d.push_back({bus.m_last, bus.m_data});
            if (bus.frame_ok) obs_ok++;
            if (bus.err_pulse) obs_err.push_back(bus.err_code);
            if (bus.overrun) obs_ov++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d = bus.m_data;
            prev_l = bus.m_last;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, kind, ng, ep, len, sum;
      logic [7:0] x;
      logic [7:0] fq [$];

      vt[0].b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h00, 8'h00};
      vt[0].nb = 6; vt[0].err_pos = -1; vt[0].exp_frames = 1; vt[0].exp_err = -1;
      vt[0].exp_n = 3; vt[0].exp_d = '{8'h11, 8'h22, 8'h33, 8'h00};
      vt[1].b = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00};
      vt[1].nb = 5; vt[1].err_pos = -1; vt[1].exp_frames = 0; vt[1].exp_err = 2;
      vt[1].exp_n = 0; vt[1].exp_d = '{8'h00, 8'h00, 8'h00, 8'h00};
      vt[2].b = '{8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
      vt[2].nb = 4; vt[2].err_pos = -1; vt[2].exp_frames = 1; vt[2].exp_err = -1;
      vt[2].exp_n = 1; vt[2].exp_d = '{8'h7E, 8'h00, 8'h00, 8'h00};
      vt[3].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vt[3].nb = 2; vt[3].err_pos = -1; vt[3].exp_frames = 0; vt[3].exp_err = 1;
      vt[3].exp_n = 0; vt[3].exp_d = '{8'h00, 8'h00, 8'h00, 8'h00};
      vt[4].b = '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vt[4].nb = 2; vt[4].err_pos = -1; vt[4].exp_frames = 0; vt[4].exp_err = 1;
      vt[4].exp_n = 0; vt[4].exp_d = '{8'h00, 8'h00, 8'h00, 8'h00};
      vt[5].b = '{8'hA5, 8'h02, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vt[5].nb = 3; vt[5].err_pos = 2; vt[5].exp_frames = 0; vt[5].exp_err = 0;
      vt[5].exp_n = 0; vt[5].exp_d = '{8'h00, 8'h00, 8'h00, 8'h00};
      vt[6].b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00};
      vt[6].nb = 7; vt[6].err_pos = -1; vt[6].exp_frames = 1; vt[6].exp_err = -1;
      vt[6].exp_n = 1; vt[6].exp_d = '{8'h7E, 8'h00, 8'h00, 8'h00};
      vt[7].b = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E, 8'h00};
      vt[7].nb = 7; vt[7].err_pos = -1; vt[7].exp_frames = 1; vt[7].exp_err = -1;
      vt[7].exp_n = 4; vt[7].exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};

      rst = 1'b1;
      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(1);
      clear_obs();

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < vt[v].nb; i++) send_byte(vt[v].b[i], 1'(i == vt[v].err_pos));
         wait_emit_done($sformatf("vec%0d", v));
         exp_ok = vt[v].exp_frames;
         if (vt[v].exp_err >= 0) exp_err.push_back(2'(vt[v].exp_err));
         for (int i = 0; i < vt[v].exp_n; i++)
            exp_d.push_back({1'(i == vt[v].exp_n - 1), vt[v].exp_d[i]});
         compare($sformatf("vec%0d", v));
      end

      // Silence after a payload byte: error pulse follows the TMO-th edge after that byte.
      send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h11, 1'b0);
      first = -1;
      for (int k = 1; k <= TMO + 5; k++) begin
         tick(1);
         if (bus.err_pulse && first < 0) first = k;
      end
      chk("tmo_latency", first, TMO);
      chk("tmo_code", int'(bus.err_code), 3);
      exp_err.push_back(2'd3);
      compare("tmo");

      // Byte lands on the expiry cycle: frame carries on.
      send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h11, 1'b0);
      tick(TMO - 1);
      send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h69, 1'b0);
      wait_emit_done("tmo_race");
      exp_ok = 1;
      exp_d.push_back({1'b0, 8'h11}); exp_d.push_back({1'b0, 8'h22}); exp_d.push_back({1'b1, 8'h33});
      compare("tmo_race");

      // Backpressure with toggling ready plus one byte arriving during emission.
      ready_mode = 3;
      tick(1);
      send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
      send_byte(8'h0E, 1'b0);
      chk("emit_latency_valid", int'(bus.m_valid), 1);
      chk("emit_latency_frame_ok", int'(bus.frame_ok), 1);
      chk("emit_first_data", int'(bus.m_data), 8'h01);
      ready_mode = 1;
      send_byte(8'hA5, 1'b0);
      wait_emit_done("bp");
      ready_mode = 0;
      exp_ok = 1; exp_ov = 1;
      exp_d.push_back({1'b0, 8'h01}); exp_d.push_back({1'b0, 8'h02});
      exp_d.push_back({1'b0, 8'h03}); exp_d.push_back({1'b1, 8'h04});
      compare("bp");

      // Reset in PAYLOAD, then in EMIT with m_valid high, then a clean frame.
      send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h11, 1'b0);
      rst = 1'b1;
      tick(1);
      check_zero("rst_payload");
      rst = 1'b0;
      ready_mode = 3;
      tick(1);
      send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0); send_byte(8'h32, 1'b0);
      chk("pre_rst_emit_valid", int'(bus.m_valid), 1);
      rst = 1'b1;
      tick(1);
      check_zero("rst_emit");
      rst = 1'b0;
      ready_mode = 0;
      tick(2);
      clear_obs();
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
      wait_emit_done("post_rst");
      exp_ok = 1;
      exp_d.push_back({1'b1, 8'h7E});
      compare("post_rst");

      // Random frames: good, bad checksum, bad length, or a stop-bit error somewhere.
      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         fq.delete();
         kind = int'($urandom_range(0, 3));
         ng = int'($urandom_range(0, 3));
         ep = -1;
         for (int g = 0; g < ng; g++) begin
            x = 8'($urandom_range(0, 255));
            if (x == 8'hA5) x = 8'h5A;
            fq.push_back(x);
         end
         fq.push_back(8'hA5);
         if (kind == 2) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXL + 1, 255));
            fq.push_back(8'(len));
            exp_err.push_back(2'd1);
         end else begin
            len = int'($urandom_range(1, MAXL));
            fq.push_back(8'(len));
            sum = len;
            for (int i = 0; i < len; i++) begin
               x = 8'($urandom_range(0, 255));
               fq.push_back(x);
               sum = sum + int'(x);
               if (kind == 0) exp_d.push_back({1'(i == len - 1), x});
            end
            if (kind == 1) begin
               fq.push_back(8'(sum % 256) ^ 8'($urandom_range(1, 255)));
               exp_err.push_back(2'd2);
            end else begin
               fq.push_back(8'(sum % 256));
            end
            if (kind == 0) exp_ok = 1;
            if (kind == 3) begin
               ep = int'($urandom_range(0, fq.size() - 1));
               while (fq.size() > ep + 1) void'(fq.pop_back());
               exp_err.push_back(2'd0);
            end
         end
         for (int i = 0; i < fq.size(); i++) begin
            send_byte(fq[i], 1'(i == ep));
            if (i < fq.size() - 1) tick(int'($urandom_range(0, 4)));
         end
         wait_emit_done($sformatf("rnd%0d", f));
         compare($sformatf("rnd%0d", f));
      end
      ready_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
